alu: RTL and testbench

Sequential arithmetic responder on the control unit's ALU request/done interface. It accepts one operation per `alu_req` and computes ADD and SUB in a single cycle. MUL and DIV use iterative shift-add and restoring-division datapaths. When the result is ready it presents `alu_res` with a one-cycle `alu_done` pulse, which the control unit sees while it waits in its INS_ADD/SUB/MUL/DIV states.

---
 rtl/alu.sv | 193 +++++++++++++++++++
 tb/tb_alu.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/alu.sv
// rtl/alu.sv - unsigned ALU responder: 1-cycle ADD/SUB, iterative shift-add MUL and restoring DIV.
// Define ALU_DIV_EN to build the divider; without it DIV returns 0 with alu_err set.
module alu #(
  parameter int REG_SIZE = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                alu_req,
  input  logic [1:0]          alu_operation,
  input  logic [REG_SIZE-1:0] alu_op1,
  input  logic [REG_SIZE-1:0] alu_op2,
  output logic                alu_done,
  output logic [REG_SIZE-1:0] alu_res,
  output logic                alu_err,
  output logic                alu_busy
);

  localparam int CW = $clog2(REG_SIZE + 1);
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [REG_SIZE-1:0] acc_q, acc_d;
  logic [REG_SIZE-1:0] a_q, a_d;
  logic [REG_SIZE-1:0] b_q, b_d;
  logic [REG_SIZE-1:0] res_q, res_d;
  logic                err_q, err_d;
  logic                done_q, done_d;

  logic                last_iter;
  logic [REG_SIZE-1:0] mul_sum;

  assign last_iter = (cnt_q == CW'(1));

  // MUL: a_q is the left-shifting multiplicand, b_q the right-shifting multiplier.
  always_comb begin
    mul_sum = acc_q + (b_q[0] ? a_q : '0);
  end

`ifdef ALU_DIV_EN
  // DIV: acc_q holds the partial remainder, a_q shifts dividend out and quotient in.
  logic [REG_SIZE:0]   div_shift, div_diff;
  logic                div_ge;
  logic [REG_SIZE-1:0] div_rem, div_quo;

  always_comb begin
    div_shift = {acc_q, a_q[REG_SIZE-1]};
    div_diff  = div_shift - {1'b0, b_q};
    div_ge    = (div_shift >= {1'b0, b_q});
    div_rem   = div_ge ? div_diff[REG_SIZE-1:0] : div_shift[REG_SIZE-1:0];
    div_quo   = {a_q[REG_SIZE-2:0], div_ge};
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (alu_req) begin
          if (alu_operation == OP_MUL) begin
            state_d = ST_MUL;
          end
`ifdef ALU_DIV_EN
          else if (alu_operation == 2'b11 && alu_op2 != '0) begin
            state_d = ST_DIV;
          end
`endif
        end
      end
      ST_MUL, ST_DIV: begin
        if (last_iter) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    a_d    = a_q;
    b_d    = b_q;
    res_d  = res_q;
    err_d  = err_q;
    done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (alu_req) begin
          a_d   = alu_op1;
          b_d   = alu_op2;
          acc_d = '0;
          case (alu_operation)
            OP_ADD: begin
              res_d  = alu_op1 + alu_op2;
              err_d  = 1'b0;
              done_d = 1'b1;
            end
            OP_SUB: begin
              res_d  = alu_op1 - alu_op2;
              err_d  = 1'b0;
              done_d = 1'b1;
            end
            OP_MUL: begin
              cnt_d = CW'(REG_SIZE);
            end
            default: begin
`ifdef ALU_DIV_EN
              if (alu_op2 == '0) begin
                res_d  = '1;
                err_d  = 1'b1;
                done_d = 1'b1;
              end else begin
                cnt_d = CW'(REG_SIZE);
              end
`else
              res_d  = '0;
              err_d  = 1'b1;
              done_d = 1'b1;
`endif
            end
          endcase
        end
      end
      ST_MUL: begin
        acc_d = mul_sum;
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q - CW'(1);
        if (last_iter) begin
          res_d  = mul_sum;
          err_d  = 1'b0;
          done_d = 1'b1;
        end
      end
`ifdef ALU_DIV_EN
      ST_DIV: begin
        acc_d = div_rem;
        a_d   = div_quo;
        cnt_d = cnt_q - CW'(1);
        if (last_iter) begin
          res_d  = div_quo;
          err_d  = 1'b0;
          done_d = 1'b1;
        end
      end
`endif
      default: begin
        cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      acc_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      res_q  <= '0;
      err_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
      a_q    <= a_d;
      b_q    <= b_d;
      res_q  <= res_d;
      err_q  <= err_d;
      done_q <= done_d;
    end
  end

  always_comb begin
    alu_done = done_q;
    alu_res  = res_q;
    alu_err  = err_q;
    alu_busy = (state_q != ST_IDLE);
  end

endmodule

// File: tb/tb_alu.sv
// tb/tb_alu.sv - directed-vector bench for alu with REG_SIZE=8, DIV expectations follow ALU_DIV_EN.
module tb_alu;

  logic       clk;
  logic       rst;
  logic       alu_req;
  logic [1:0] alu_operation;
  logic [7:0] alu_op1;
  logic [7:0] alu_op2;
  logic       alu_done;
  logic [7:0] alu_res;
  logic       alu_err;
  logic       alu_busy;

  int total = 0;
  int bad   = 0;

  alu #(.REG_SIZE(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .alu_req      (alu_req),
    .alu_operation(alu_operation),
    .alu_op1      (alu_op1),
    .alu_op2      (alu_op2),
    .alu_done     (alu_done),
    .alu_res      (alu_res),
    .alu_err      (alu_err),
    .alu_busy     (alu_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Issue one op at the current negedge and follow it to its done pulse.
  // done_edge = index of the edge (relative to E0) that raised alu_done.
  task automatic do_op(input string tag, input logic [1:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic [7:0] exp_res, input logic exp_err,
                       input int exp_edge);
    int  n;
    int  busy_n;
    bit  got;
    n = 0; busy_n = 0; got = 1'b0;
    alu_req = 1'b1; alu_operation = op; alu_op1 = a; alu_op2 = b;
    while (!got && n < 40) begin
      @(negedge clk);
      alu_req = 1'b0;
      n++;
      if (alu_done) got = 1'b1;
      else if (alu_busy) busy_n++;
    end
    check({tag, "_res"}, alu_res, exp_res);
    check({tag, "_err"}, alu_err, exp_err);
    check({tag, "_done_edge"}, n - 1, exp_edge);
    check({tag, "_busy_cycles"}, busy_n, exp_edge);
    check({tag, "_busy_at_done"}, alu_busy, 0);
    @(negedge clk);
    check({tag, "_single_pulse"}, alu_done, 0);
  endtask

  initial begin
    int n;
    int pulses;
    int first_n;
    int second_n;
    bit got;

    rst = 1'b1; alu_req = 1'b0; alu_operation = 2'b00; alu_op1 = 8'd0; alu_op2 = 8'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_outputs", {alu_done, alu_err, alu_busy, alu_res}, 0);
    end

    do_op("add_200_100", 2'b00, 8'd200, 8'd100, 8'd44, 1'b0, 0);
    do_op("sub_5_7", 2'b01, 8'd5, 8'd7, 8'd254, 1'b0, 0);
    do_op("mul_13_11", 2'b10, 8'd13, 8'd11, 8'd143, 1'b0, 8);
    do_op("mul_20_20", 2'b10, 8'd20, 8'd20, 8'd144, 1'b0, 8);
`ifdef ALU_DIV_EN
    do_op("div_200_7", 2'b11, 8'd200, 8'd7, 8'd28, 1'b0, 8);
    do_op("div_9_0", 2'b11, 8'd9, 8'd0, 8'd255, 1'b1, 0);
    do_op("div_255_1", 2'b11, 8'd255, 8'd1, 8'd255, 1'b0, 8);
`else
    do_op("div_200_7_nodiv", 2'b11, 8'd200, 8'd7, 8'd0, 1'b1, 0);
    do_op("div_9_0_nodiv", 2'b11, 8'd9, 8'd0, 8'd0, 1'b1, 0);
`endif
    do_op("add_clears_err", 2'b00, 8'd255, 8'd1, 8'd0, 1'b0, 0);

    // Request during MUL is ignored; then ADD issued in the done cycle.
    alu_req = 1'b1; alu_operation = 2'b10; alu_op1 = 8'd3; alu_op2 = 8'd4;
    n = 0; got = 1'b0; pulses = 0;
    while (!got && n < 30) begin
      @(negedge clk);
      n++;
      alu_req = 1'b0;
      if (alu_done) begin
        got = 1'b1;
        pulses++;
      end
      if (!got && n == 3) begin
        alu_req = 1'b1; alu_operation = 2'b00; alu_op1 = 8'd1; alu_op2 = 8'd1;
      end
    end
    check("ignore_done_edge", n - 1, 8);
    check("ignore_res", alu_res, 12);
    alu_req = 1'b1; alu_operation = 2'b00; alu_op1 = 8'd1; alu_op2 = 8'd1;
    @(negedge clk);
    alu_req = 1'b0;
    check("b2b_done", alu_done, 1);
    check("b2b_res", alu_res, 2);
    @(negedge clk);
    check("b2b_single_pulse", alu_done, 0);

    // Reset at E0+4 of MUL aborts; reset also beats a simultaneous request.
    alu_req = 1'b1; alu_operation = 2'b10; alu_op1 = 8'd15; alu_op2 = 8'd15;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      alu_req = 1'b0;
    end
    rst = 1'b1;
    alu_req = 1'b1; alu_operation = 2'b00; alu_op1 = 8'd1; alu_op2 = 8'd1;
    @(negedge clk);
    rst = 1'b0; alu_req = 1'b0;
    check("abort_outputs", {alu_done, alu_err, alu_busy, alu_res}, 0);
    pulses = 0;
    repeat (15) begin
      @(negedge clk);
      if (alu_done) pulses++;
    end
    check("abort_no_done", pulses, 0);
    do_op("add_after_abort", 2'b00, 8'd1, 8'd2, 8'd3, 1'b0, 0);

    // ADD held high: done every cycle.
    alu_req = 1'b1; alu_operation = 2'b00; alu_op1 = 8'd1; alu_op2 = 8'd1;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (alu_done && alu_res == 8'd2) pulses++;
    end
    alu_req = 1'b0;
    check("held_add_pulses", pulses, 20);
    @(negedge clk);
    check("held_add_stop", alu_done, 0);

    // MUL held high: done raised at edges E0+8 and E0+17.
    alu_req = 1'b1; alu_operation = 2'b10; alu_op1 = 8'd2; alu_op2 = 8'd3;
    n = 0; pulses = 0; first_n = -1; second_n = -1;
    while (pulses < 2 && n < 40) begin
      @(negedge clk);
      n++;
      if (alu_done) begin
        pulses++;
        if (pulses == 1) first_n = n - 1;
        else begin
          second_n = n - 1;
          alu_req = 1'b0;
        end
        check("held_mul_res", alu_res, 6);
      end
    end
    alu_req = 1'b0;
    check("held_mul_first_edge", first_n, 8);
    check("held_mul_second_edge", second_n, 17);
    repeat (3) @(negedge clk);
    check("held_mul_idle_busy", alu_busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
